conv_loop_ctrl: RTL
===================

# conv_loop_ctrl

Parametrised convolution-layer sequencer for the accelerator datapath. It replaces externally driven loop indices with internal nested loop counters. On a start pulse it walks one full layer: output channel m, output row r, output column c, input-channel group ng, kernel row i, kernel column j. Each cycle it issues input-feature-map and weight buffer addresses together with accumulator framing flags. It drives the output-buffer write through a parametrised fixed-latency delay line and reports completion with a busy/done handshake.

## Interface
Parameters:
- K, 5: kernel size (K×K), stride 1, no padding
- IN_SIZE, 32: input feature map width and height
- OUT_SIZE, 28: output width and height; must equal IN_SIZE−K+1
- IN_CH, 1: input channels
- OUT_CH, 6: output channels
- PAR_N, 4: input channels consumed in parallel per address; NG = ceil(IN_CH/PAR_N)
- PIPE_LAT, 8: cycles from a tap's address issue to the MAC result being ready (≥1)
- ADDR_W, 16: address width; elaboration fails if any maximum address ≥ 2^ADDR_W

Ports:
- clock  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a layer; sampled only in IDLE
- hold  in  1  stall the issue side (bubble insert)
- busy  out  1  layer in progress
- done  out  1  one-cycle completion pulse
- mem_en  out  1  ifm/weight addresses valid this cycle
- ifm_addr  out  ADDR_W  ng·IN_SIZE² + (r+i)·IN_SIZE + (c+j)
- weight_addr  out  ADDR_W  m·NG·K² + ng·K² + i·K + j
- acc_first  out  1  qualifies the first tap of an output pixel (ng=i=j=0)
- acc_last  out  1  qualifies the last tap of an output pixel (ng=NG−1, i=j=K−1)
- out_we  out  1  output buffer write strobe
- out_addr  out  ADDR_W  m·OUT_SIZE² + r·OUT_SIZE + c

## Operation
- States: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE: start=1 → RUN; all counters zero.
- RUN: each cycle with hold=0 registers the current tap onto the outputs with mem_en=1, then advances the counters. j is the innermost loop, then i, ng, c, r, m. Each counter wraps to 0 and carries into the next.
- Cycles with hold=1 in RUN: counters freeze, mem_en=0, acc_first=acc_last=0, addresses hold their last value.
- After the final tap (m=OUT_CH−1, r=c=OUT_SIZE−1, ng=NG−1, i=j=K−1) is issued → DRAIN.
- Each acc_last issue pushes a valid token with its out_addr into a PIPE_LAT-deep delay line.
- The delay line always advances; hold does not stall it. Its output drives out_we and out_addr.
- DRAIN lasts until the last token exits (out_we of pixel OUT_CH·OUT_SIZE²−1), then → DONE.
- DONE: done=1 for one cycle → IDLE.
- busy=1 in RUN, DRAIN and DONE.
- start outside IDLE is ignored, including during DONE.
- All address arithmetic is unsigned, computed at full width and truncated to ADDR_W.
- Tap count T = OUT_CH·OUT_SIZE²·NG·K². With no hold, mem_en is high for exactly T cycles.

## Timing
- Reset values (asynchronous, immediate): state IDLE; busy, done, mem_en, acc_first, acc_last, out_we = 0; ifm_addr, weight_addr, out_addr = 0; delay line flushed.
- Reset mid-layer aborts the layer. No out_we issues afterwards.
- start high at edge E → busy=1 and mem_en=1 with tap 0 in the cycle after E.
- Tap issue latency 1 cycle from counter state to registered outputs.
- acc_first and acc_last are coincident with their tap's mem_en.
- A tap issued in cycle x with acc_last=1 → out_we=1 in cycle x+PIPE_LAT.
- If K=1 and NG=1, acc_first and acc_last are both high on every tap.
- done is high in the cycle after the final out_we. busy falls together with done's deassertion.
- With no hold, layer duration is T+PIPE_LAT+1 cycles after E.

## Test plan
- Reset: drive rst_n=0 mid-RUN → all outputs 0 asynchronously; after release, start → ifm_addr=0, weight_addr=0 on first mem_en.
- Small config (K=3, IN_SIZE=5, OUT_SIZE=3, IN_CH=1, OUT_CH=2, PIPE_LAT=4):
  - ifm_addr sequence starts 0,1,2,5,6,7,10,11,12.
  - Pixel c=1 starts at ifm_addr 1.
  - m=1 starts at weight_addr 9.
  - mem_en count 162, out_we count 18, out_addr 0..17 in order.
  - done in cycle E+167.
- Grouping (IN_CH=6, PAR_N=4, same sizes): NG=2.
  - The 10th tap of pixel 0 has ifm_addr 25 and weight_addr 9.
  - m=1 starts at weight_addr 18.
  - acc_last every 18th tap.
- Hold: assert hold for 3 cycles mid-pixel → mem_en low for 3 cycles, addresses frozen, no tap skipped or repeated. Total mem_en is still 162; done is delayed by 3 cycles.
- Protocol: start pulses during RUN, DRAIN and DONE → ignored, no change to counts. start in the cycle after done → new layer begins at address 0.
- Edge config (K=1, OUT_SIZE=IN_SIZE=4, OUT_CH=1, PIPE_LAT=1) → acc_first=acc_last on every tap; out_we trails each tap by 1 cycle; 16 writes.

Source files
------------

// File: rtl/conv_loop_ctrl.sv
// ============================================================================
// Module   : conv_loop_ctrl
// Brief    : Convolution-layer sequencer. Walks m, r, c, ng, i, j and issues
//            ifm/weight addresses, accumulator framing and delayed out writes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module conv_loop_ctrl #(
  parameter int K        = 5,
  parameter int IN_SIZE  = 32,
  parameter int OUT_SIZE = 28,
  parameter int IN_CH    = 1,
  parameter int OUT_CH   = 6,
  parameter int PAR_N    = 4,
  parameter int PIPE_LAT = 8,
  parameter int ADDR_W   = 16
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] ifm_addr,
  output logic [ADDR_W-1:0] weight_addr,
  output logic              acc_first,
  output logic              acc_last,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr
);

  localparam int c_NG  = (IN_CH + PAR_N - 1) / PAR_N;
  localparam int c_KW  = (K > 1)        ? $clog2(K)        : 1;
  localparam int c_NGW = (c_NG > 1)     ? $clog2(c_NG)     : 1;
  localparam int c_OW  = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int c_MW  = (OUT_CH > 1)   ? $clog2(OUT_CH)   : 1;

  localparam logic [ADDR_W-1:0] c_IN        = ADDR_W'(IN_SIZE);
  localparam logic [ADDR_W-1:0] c_IN_PLANE  = ADDR_W'(IN_SIZE * IN_SIZE);
  localparam logic [ADDR_W-1:0] c_KK        = ADDR_W'(K);
  localparam logic [ADDR_W-1:0] c_KSQ       = ADDR_W'(K * K);
  localparam logic [ADDR_W-1:0] c_W_PER_M   = ADDR_W'(c_NG * K * K);
  localparam logic [ADDR_W-1:0] c_OUT       = ADDR_W'(OUT_SIZE);
  localparam logic [ADDR_W-1:0] c_OUT_PLANE = ADDR_W'(OUT_SIZE * OUT_SIZE);
  localparam logic [ADDR_W-1:0] c_LAST_PIX  = ADDR_W'(OUT_CH * OUT_SIZE * OUT_SIZE - 1);

  localparam longint c_ADDR_LIM = longint'(1) << ADDR_W;
  localparam longint c_IFM_MAX  = longint'(c_NG) * IN_SIZE * IN_SIZE - 1;
  localparam longint c_WT_MAX   = longint'(OUT_CH) * c_NG * K * K - 1;
  localparam longint c_OUT_MAX  = longint'(OUT_CH) * OUT_SIZE * OUT_SIZE - 1;

  // Configuration sanity: refuse to elaborate an inconsistent geometry.
  if (OUT_SIZE != IN_SIZE - K + 1) begin : g_chk_out_size
    $error("conv_loop_ctrl: OUT_SIZE must equal IN_SIZE-K+1");
  end
  if (PIPE_LAT < 1) begin : g_chk_pipe_lat
    $error("conv_loop_ctrl: PIPE_LAT must be at least 1");
  end
  if (ADDR_W < 1 || ADDR_W > 62) begin : g_chk_addr_w
    $error("conv_loop_ctrl: ADDR_W out of range");
  end
  if (c_IFM_MAX >= c_ADDR_LIM) begin : g_chk_ifm
    $error("conv_loop_ctrl: ifm address exceeds ADDR_W");
  end
  if (c_WT_MAX >= c_ADDR_LIM) begin : g_chk_weight
    $error("conv_loop_ctrl: weight address exceeds ADDR_W");
  end
  if (c_OUT_MAX >= c_ADDR_LIM) begin : g_chk_out
    $error("conv_loop_ctrl: output address exceeds ADDR_W");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [c_MW-1:0]  r_m;
  logic [c_OW-1:0]  r_r;
  logic [c_OW-1:0]  r_c;
  logic [c_NGW-1:0] r_ng;
  logic [c_KW-1:0]  r_i;
  logic [c_KW-1:0]  r_j;

  logic w_j_end;
  logic w_i_end;
  logic w_ng_end;
  logic w_c_end;
  logic w_r_end;
  logic w_m_end;
  logic w_first;
  logic w_pix_end;
  logic w_final;
  logic w_issue;

  logic [ADDR_W-1:0] w_ifm;
  logic [ADDR_W-1:0] w_wt;
  logic [ADDR_W-1:0] w_pix;
  logic [ADDR_W-1:0] r_tap_pix;

  logic              r_dly_vld  [PIPE_LAT];
  logic [ADDR_W-1:0] r_dly_addr [PIPE_LAT];

  assign w_j_end   = (r_j  == c_KW'(K - 1));
  assign w_i_end   = (r_i  == c_KW'(K - 1));
  assign w_ng_end  = (r_ng == c_NGW'(c_NG - 1));
  assign w_c_end   = (r_c  == c_OW'(OUT_SIZE - 1));
  assign w_r_end   = (r_r  == c_OW'(OUT_SIZE - 1));
  assign w_m_end   = (r_m  == c_MW'(OUT_CH - 1));
  assign w_first   = (r_ng == '0) && (r_i == '0) && (r_j == '0);
  assign w_pix_end = w_j_end && w_i_end && w_ng_end;
  assign w_final   = w_pix_end && w_c_end && w_r_end && w_m_end;

  // Address arithmetic at ADDR_W width; overflow is ruled out at elaboration.
  assign w_ifm = ADDR_W'(r_ng) * c_IN_PLANE
               + (ADDR_W'(r_r) + ADDR_W'(r_i)) * c_IN
               + ADDR_W'(r_c) + ADDR_W'(r_j);
  assign w_wt  = ADDR_W'(r_m) * c_W_PER_M + ADDR_W'(r_ng) * c_KSQ
               + ADDR_W'(r_i) * c_KK + ADDR_W'(r_j);
  assign w_pix = ADDR_W'(r_m) * c_OUT_PLANE + ADDR_W'(r_r) * c_OUT + ADDR_W'(r_c);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The start cycle itself issues tap 0, so the first tap lands one cycle after start.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_issue     = !hold;
          w_state_nxt = (!hold && w_final) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        w_issue = !hold;
        if (!hold && w_final) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_we && (out_addr == c_LAST_PIX)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_m  <= '0;
      r_r  <= '0;
      r_c  <= '0;
      r_ng <= '0;
      r_i  <= '0;
      r_j  <= '0;
    end else if (w_issue) begin
      r_j <= w_j_end ? '0 : r_j + c_KW'(1);
      if (w_j_end) begin
        r_i <= w_i_end ? '0 : r_i + c_KW'(1);
        if (w_i_end) begin
          r_ng <= w_ng_end ? '0 : r_ng + c_NGW'(1);
          if (w_ng_end) begin
            r_c <= w_c_end ? '0 : r_c + c_OW'(1);
            if (w_c_end) begin
              r_r <= w_r_end ? '0 : r_r + c_OW'(1);
              if (w_r_end) begin
                r_m <= w_m_end ? '0 : r_m + c_MW'(1);
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      mem_en      <= 1'b0;
      acc_first   <= 1'b0;
      acc_last    <= 1'b0;
      ifm_addr    <= '0;
      weight_addr <= '0;
      r_tap_pix   <= '0;
    end else begin
      mem_en    <= w_issue;
      acc_first <= w_issue && w_first;
      acc_last  <= w_issue && w_pix_end;
      if (w_issue) begin
        ifm_addr    <= w_ifm;
        weight_addr <= w_wt;
        r_tap_pix   <= w_pix;
      end
    end
  end

  // Fed from the registered acc_last so out_we trails it by exactly PIPE_LAT cycles.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < PIPE_LAT; s++) begin
        r_dly_vld[s]  <= 1'b0;
        r_dly_addr[s] <= '0;
      end
    end else begin
      r_dly_vld[0]  <= acc_last;
      r_dly_addr[0] <= r_tap_pix;
      for (int s = 1; s < PIPE_LAT; s++) begin
        r_dly_vld[s]  <= r_dly_vld[s-1];
        r_dly_addr[s] <= r_dly_addr[s-1];
      end
    end
  end

  assign out_we   = r_dly_vld[PIPE_LAT-1];
  assign out_addr = r_dly_addr[PIPE_LAT-1];

endmodule

`default_nettype wire
